// File: rtl/query_pkg.sv
// Shared definitions for the query patch memory read path.
//   DATA_WIDTH / PATCH_SIZE / ADDR_WIDTH : geometry of the query patch memory
//   PATCH_W                              : bits per stored patch
//   ENTRY_W                              : output buffer entry (patch + source address)
//   patch_t, addr_t, count_t             : common vector types
//   state_t                              : streamer sequencing states
package query_pkg;

  localparam int DATA_WIDTH = 11;
  localparam int PATCH_SIZE = 5;
  localparam int ADDR_WIDTH = 9;
  localparam int PATCH_W    = DATA_WIDTH * PATCH_SIZE;
  localparam int ENTRY_W    = PATCH_W + ADDR_WIDTH;

  typedef logic [PATCH_W-1:0]    patch_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  // One bit wider than an address so a full-memory sweep (2^ADDR_WIDTH) fits.
  typedef logic [ADDR_WIDTH:0]   count_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  typedef struct packed {
    patch_t patch;
    addr_t  idx;
  } entry_t;

endpackage

// File: rtl/patch_skid_fifo.sv
// Two-entry output buffer between the memory return path and the consumer.
//   clk, reset : clock and synchronous active-high reset
//   push       : write push_data this cycle (caller guarantees space)
//   push_data  : entry to store
//   pop        : consume the head entry this cycle (caller guarantees non-empty)
//   pop_data   : head entry, stable until popped
//   count      : number of stored entries, 0..2
module patch_skid_fifo
  import query_pkg::*;
#(
  parameter int WIDTH = ENTRY_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;

  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the two storage entries are reset because the head entry drives
      // out_patch/out_idx directly and those must read zero after reset.
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/query_patch_streamer.sv
// Read-side sequencer for the query patch memory. A start pulse walks a
// contiguous (wrapping) address range on read port 1 and streams each patch,
// tagged with its address, to the kNN pipeline over valid/ready.
//   clk, reset          : clock and synchronous active-high reset
//   start               : launch pulse, honoured only when idle
//   start_addr          : first patch address (sampled with start)
//   num_patches         : patch count 0..2^ADDR_WIDTH (sampled with start)
//   busy                : run in progress (cycle after start through done)
//   done                : single-cycle pulse on the last output handshake
//   csb1, addr1         : memory port-1 chip select (active low) and address
//   rpatch1             : memory port-1 read data, one cycle after csb1 low
//   out_valid/out_ready : output stream handshake
//   out_patch, out_idx  : patch data and the address it came from
module query_patch_streamer
  import query_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   num_patches,
  output logic                  busy,
  output logic                  done,
  output logic                  csb1,
  output logic [ADDR_WIDTH-1:0] addr1,
  input  logic [PATCH_W-1:0]    rpatch1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PATCH_W-1:0]    out_patch,
  output logic [ADDR_WIDTH-1:0] out_idx
);

  state_t     state;
  addr_t      rd_addr;
  addr_t      addr_hold;      // last issued address, shown on addr1 between reads
  addr_t      inflight_addr;  // address of the read whose data returns this cycle
  count_t     issue_left;
  count_t     out_left;
  logic       inflight;
  logic       zero_done;      // done pulse for an empty request
  logic [1:0] fifo_count;
  logic [2:0] credit_used;
  logic       pop;
  logic       issue;
  logic       last_pop;
  entry_t     fifo_in;
  entry_t     fifo_head;

  assign out_valid = (fifo_count != 2'd0);
  assign pop       = out_valid & out_ready;

  // Slots that will still be occupied after this cycle's pop. Issuing only
  // while this is below two keeps buffered + in-flight patches within the
  // two buffer entries, so the buffer can never overflow.
  assign credit_used = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign issue       = (state == RUN) && (issue_left != '0) && (credit_used < 3'd2);

  assign csb1 = ~issue;
  assign addr1 = issue ? rd_addr : addr_hold;

  assign last_pop = pop && (state == DRAIN) && (out_left == count_t'(1));
  assign done     = last_pop | zero_done;
  assign busy     = (state != IDLE);

  assign fifo_in   = '{patch: rpatch1, idx: inflight_addr};
  assign out_patch = fifo_head.patch;
  assign out_idx   = fifo_head.idx;

  patch_skid_fifo #(
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .push_data (fifo_in),
    .pop       (pop),
    .pop_data  (fifo_head),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      rd_addr       <= '0;
      addr_hold     <= '0;
      inflight_addr <= '0;
      issue_left    <= '0;
      out_left      <= '0;
      inflight      <= 1'b0;
      zero_done     <= 1'b0;
    end else begin
      // NOTE: every register here uses <= so all updates see the same
      // pre-edge values regardless of statement order.
      zero_done <= 1'b0;
      inflight  <= issue;

      if (issue) begin
        inflight_addr <= rd_addr;
        addr_hold     <= rd_addr;
        rd_addr       <= rd_addr + addr_t'(1);
        issue_left    <= issue_left - count_t'(1);
      end

      if (pop && (state != IDLE)) begin
        out_left <= out_left - count_t'(1);
      end

      case (state)
        IDLE: begin
          if (start) begin
            rd_addr    <= start_addr;
            issue_left <= num_patches;
            out_left   <= num_patches;
            if (num_patches == '0) begin
              zero_done <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (issue && (issue_left == count_t'(1))) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_pop) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_query_patch_streamer.sv
module tb_query_patch_streamer;
  import query_pkg::*;

  localparam int MEM_DEPTH = 1 << ADDR_WIDTH;

  logic                  clk;
  logic                  reset;
  logic                  start;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [ADDR_WIDTH:0]   num_patches;
  logic                  busy;
  logic                  done;
  logic                  csb1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [PATCH_W-1:0]    rpatch1;
  logic                  out_valid;
  logic                  out_ready;
  logic [PATCH_W-1:0]    out_patch;
  logic [ADDR_WIDTH-1:0] out_idx;

  patch_t tb_mem [MEM_DEPTH];
  int     vectors;
  int     miscompares;

  query_patch_streamer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .start_addr  (start_addr),
    .num_patches (num_patches),
    .busy        (busy),
    .done        (done),
    .csb1        (csb1),
    .addr1       (addr1),
    .rpatch1     (rpatch1),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_patch   (out_patch),
    .out_idx     (out_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Query patch memory model: one-cycle synchronous read on port 1.
  always @(posedge clk) begin
    if (!csb1) rpatch1 <= tb_mem[addr1];
  end

  // One complete run. The reference is the plain address arithmetic
  // (sa + k) mod 2^ADDR_WIDTH for the k-th read and the k-th delivered patch.
  // mode 0: out_ready always 1, 1: pattern 1,0,0,1, 2: random.
  // extra_at >= 0 pulses a second start at that cycle, which must be ignored.
  task automatic run_job(input int sa, input int n, input int mode, input int extra_at);
    int     issued, accepted, first_valid, done_cyc, exp_a;
    bit     done_seen, stalled, exp_done, exp_busy;
    addr_t  held_idx;
    patch_t held_patch;
    issued = 0; accepted = 0; first_valid = -1; done_cyc = -1;
    done_seen = 1'b0; stalled = 1'b0; held_idx = '0; held_patch = '0;
    for (int c = 0; c < 4 * n + 30 && !done_seen; c++) begin
      @(negedge clk);
      start       = (c == 0) || (c == extra_at);
      start_addr  = (c == 0) ? addr_t'(sa) : addr_t'($urandom);
      num_patches = (c == 0) ? count_t'(n) : count_t'(3);
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((c % 4) == 0) || ((c % 4) == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (stalled) begin
        vectors++;
        if (!out_valid || out_idx !== held_idx || out_patch !== held_patch) begin
          miscompares++;
          $display("FAIL stall_hold c=%0d valid=%0b idx=%0d exp_idx=%0d patch=%h exp_patch=%h",
                   c, out_valid, out_idx, held_idx, out_patch, held_patch);
        end
      end
      if (!csb1) begin
        exp_a = (sa + issued) % MEM_DEPTH;
        vectors++;
        if (addr1 !== addr_t'(exp_a)) begin
          miscompares++;
          $display("FAIL addr1 c=%0d got=%0d exp=%0d", c, addr1, exp_a);
        end
        issued++;
      end
      if (out_valid && first_valid < 0) first_valid = c;
      if (out_valid && out_ready) begin
        exp_a = (sa + accepted) % MEM_DEPTH;
        vectors++;
        if (out_idx !== addr_t'(exp_a) || out_patch !== tb_mem[exp_a]) begin
          miscompares++;
          $display("FAIL out_data c=%0d idx=%0d exp_idx=%0d patch=%h exp_patch=%h",
                   c, out_idx, exp_a, out_patch, tb_mem[exp_a]);
        end
        accepted++;
      end
      vectors++;
      if (issued - accepted > 2) begin
        miscompares++;
        $display("FAIL outstanding c=%0d got=%0d exp<=2", c, issued - accepted);
      end
      exp_done = (n == 0) ? (c == 1) : (out_valid && out_ready && accepted == n);
      vectors++;
      if (done !== exp_done) begin
        miscompares++;
        $display("FAIL done c=%0d got=%0b exp=%0b", c, done, exp_done);
      end
      exp_busy = (n > 0) && (c >= 1);
      vectors++;
      if (busy !== exp_busy) begin
        miscompares++;
        $display("FAIL busy c=%0d got=%0b exp=%0b", c, busy, exp_busy);
      end
      stalled    = out_valid && !out_ready;
      held_idx   = out_idx;
      held_patch = out_patch;
      if (done) begin
        done_seen = 1'b1;
        done_cyc  = c;
      end
    end
    start = 1'b0;
    vectors++;
    if (!done_seen) begin
      miscompares++;
      $display("FAIL timeout sa=%0d n=%0d got=no_done exp=done", sa, n);
    end
    vectors++;
    if (issued != n || accepted != n) begin
      miscompares++;
      $display("FAIL counts n=%0d reads=%0d delivered=%0d exp=%0d", n, issued, accepted, n);
    end
    if (n == 0) begin
      vectors++;
      if (first_valid != -1) begin
        miscompares++;
        $display("FAIL zero_valid got_first=%0d exp=-1", first_valid);
      end
    end
    if (mode == 0 && n > 0) begin
      vectors++;
      if (first_valid != 3 || done_cyc != n + 2) begin
        miscompares++;
        $display("FAIL latency n=%0d first_valid=%0d exp=3 done_cyc=%0d exp=%0d",
                 n, first_valid, done_cyc, n + 2);
      end
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
      #1;
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0 || csb1 !== 1'b1 || out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_after busy=%0b done=%0b csb1=%0b valid=%0b exp=0,0,1,0",
                 busy, done, csb1, out_valid);
      end
      if (n > 0) begin
        exp_a = (sa + n - 1) % MEM_DEPTH;
        vectors++;
        if (addr1 !== addr_t'(exp_a)) begin
          miscompares++;
          $display("FAIL addr1_hold got=%0d exp=%0d", addr1, exp_a);
        end
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || csb1 !== 1'b1 || addr1 !== '0 ||
        out_valid !== 1'b0 || out_patch !== '0 || out_idx !== '0) begin
      miscompares++;
      $display("FAIL %s busy=%0b done=%0b csb1=%0b addr1=%0d valid=%0b patch=%h idx=%0d exp=0,0,1,0,0,0,0",
               tag, busy, done, csb1, addr1, out_valid, out_patch, out_idx);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_reset_values("reset_state");
    reset = 1'b0;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) tb_mem[i] = patch_t'(i);
    run_job(0, 4, 0, -1);
  endtask

  task automatic test_wrap();
    run_job(510, 4, 0, -1);
  endtask

  task automatic test_backpressure();
    run_job(int'($urandom_range(0, MEM_DEPTH - 1)), 8, 1, -1);
  endtask

  task automatic test_zero();
    run_job(int'($urandom_range(0, MEM_DEPTH - 1)), 0, 0, -1);
  endtask

  task automatic test_start_ignored();
    run_job(int'($urandom_range(0, MEM_DEPTH - 1)), 6, 1, 3);
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    start       = 1'b1;
    start_addr  = addr_t'($urandom);
    num_patches = count_t'(6);
    out_ready   = 1'b0;
    repeat (5) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1;
    vectors++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL stalled_run valid=%0b busy=%0b exp=1,1", out_valid, busy);
    end
    reset = 1'b1;
    @(negedge clk);
    #1;
    check_reset_values("reset_mid_run");
    reset = 1'b0;
    run_job(int'($urandom_range(0, MEM_DEPTH - 1)), 2, 0, -1);
  endtask

  task automatic test_back_to_back();
    run_job(int'($urandom_range(0, MEM_DEPTH - 1)), 3, 0, -1);
    run_job(int'($urandom_range(0, MEM_DEPTH - 1)), 5, 2, -1);
  endtask

  task automatic test_full_range();
    run_job(int'($urandom_range(0, MEM_DEPTH - 1)), MEM_DEPTH, 0, -1);
  endtask

  task automatic test_random();
    for (int j = 0; j < 6; j++) begin
      run_job(int'($urandom_range(0, MEM_DEPTH - 1)), int'($urandom_range(1, 24)), 2, -1);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    start       = 1'b0;
    start_addr  = '0;
    num_patches = '0;
    out_ready   = 1'b0;
    rpatch1     = '0;
    for (int i = 0; i < MEM_DEPTH; i++) tb_mem[i] = patch_t'({$urandom, $urandom});

    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    test_full_range();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
